mc_ctrl_fsm: RTL
================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 Parameter OP_W, default 7: opcode width; class field = ir[OP_W-1:OP_W-4], sub field = ir[2:0]; OP_W SHALL be >= 7.
REQ-002 Parameter STACK_UP, default 0: 0 = push decrements SP, 1 = push increments SP; pop does the opposite.
REQ-003 Parameter VEC_EN, default 1: 1 = interrupt entry enabled, 0 = irq ignored.
REQ-004 clk  input  1  system clock, all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; forces S_RST.
REQ-006 ir  input  OP_W  current instruction register contents.
REQ-007 dcond  input  1  branch condition from datapath.
REQ-008 mem_ready  input  1  memory completes read/write this cycle.
REQ-009 irq  input  1  level interrupt request.
REQ-010 ld_en  output  6  register load enables, index IR,MDR,MAR,SP,PC,T.
REQ-011 tr_en  output  7  bus drive enables, index IR,MDR,MAR,SP,PC,T,VEC; at most one bit high per cycle.
REQ-012 rd / wr  output  1 each  register-file read / write strobe.
REQ-013 memrd / memwr  output  1 each  memory read / write strobe.
REQ-014 fnsel  output  3  ALU op: ADD 000, NEG 001, INC 010, DEC 011, OR 100, NOT 101, TRANS 110.
REQ-015 fn_ctl  output  1  1 = fnsel drives ALU, 0 = datapath chooses function.
REQ-016 irq_ack  output  1  one-cycle pulse on vector load.
REQ-017 halted  output  1  high while in S_HALT.
REQ-018 state  output  5  current state code, for debug.

Function
REQ-019 Outputs SHALL be Moore: decoded from state register only; any unlisted output 0, fnsel 000, fn_ctl 0.
REQ-020 Fetch: F_A (ld MAR, tr PC, TRANS) -> F_B (memrd, tr MAR, ld IR; hold until mem_ready) -> F_C (ld PC, tr PC, INC) -> dispatch.
REQ-021 Dispatch from F_C: class 1111 sub 000 PUSH; 1111 other POP; 1001 CALL; 1000 RET; 1110 HALT; 0xxx with dcond=1 BRANCH; anything else -> NEXT.
REQ-022 BRANCH: B_A (ld T, tr IR, fn_ctl 0) -> B_B (ld PC, tr T, ADD) -> NEXT.
REQ-023 PUSH: P_A (ld MDR, rd, TRANS) -> P_B (ld SP, tr SP, DEC, or INC if STACK_UP) -> P_C (ld MAR, tr SP, TRANS) -> P_D (memwr, tr MDR; hold until mem_ready) -> exit.
REQ-024 CALL: C_A (ld MDR, tr PC, TRANS) -> P_B..P_D -> B_A -> B_B -> NEXT.
REQ-025 POP: O_A (ld MAR, tr SP, TRANS) -> O_B (memrd, ld MDR; hold until mem_ready) -> O_C (ld SP, tr SP, INC, or DEC if STACK_UP) -> O_D (ld T, tr MDR) -> O_E (tr T, wr) -> NEXT.
REQ-026 RET: O_A..O_C -> R_A (ld PC, tr MDR, TRANS) -> NEXT; RET SHALL set interrupt-enable flag ie.
REQ-027 P_D exit: CALL -> B_A, interrupt entry -> I_B, else NEXT.
REQ-028 NEXT = I_A when VEC_EN and irq and ie, else F_A.
REQ-029 Interrupt: I_A (ld MDR, tr PC, TRANS, clear ie) -> P_B..P_D -> I_B (ld PC, tr VEC, TRANS, irq_ack) -> F_A.
REQ-030 HALT: S_HALT, all strobes 0, halted 1; leave to I_A when VEC_EN and irq and ie, else stay.
REQ-031 mem_ready low SHALL hold F_B/O_B/P_D with all outputs stable; irq arriving mid-instruction is only taken at NEXT.
REQ-032 Undefined state codes SHALL go to S_RST next cycle.

Reset
REQ-033 reset high: state = S_RST (00000) immediately, ie = 1, all outputs 0.
REQ-034 S_RST -> F_A on first clock with reset low; reset mid-instruction abandons it with no memwr.

Structure
REQ-035 Package mc_ctrl_pkg: state codes, fnsel codes, ld_en/tr_en index constants, class codes.
REQ-036 Single module; no sub-module needed; 5-bit binary state register plus ie flip-flop.

Verification
REQ-037 Reset release, ir=0x00, dcond=0, mem_ready=1 -> F_A,F_B,F_C,F_A loop; PC INC once per 3 cycles.
REQ-038 ir=0x05, dcond=1 -> B_A with tr_en[IR], fn_ctl=0, then B_B with fnsel=000, ld_en[PC].
REQ-039 CALL ir=0x48, STACK_UP=0, mem_ready low 3 cycles in P_D -> P_D held 4 cycles, fnsel=011 in P_B, then B_A.
REQ-040 irq=1 during POP -> POP completes; I_A, P_B..P_D, I_B with irq_ack one cycle; second irq ignored until RET.
REQ-041 HALT ir=0x70 -> halted=1 stays; irq=1 -> I_A next cycle; reset asserted in O_B -> outputs 0 same cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the microcoded-style control FSM: state codes,
// ALU function codes, register/bus index positions and opcode class codes.
package mc_ctrl_pkg;

  // Five-bit binary state codes; codes 23..31 are unused and recover to S_RST.
  typedef enum logic [4:0] {
    S_RST  = 5'd0,
    S_F_A  = 5'd1,
    S_F_B  = 5'd2,
    S_F_C  = 5'd3,
    S_B_A  = 5'd4,
    S_B_B  = 5'd5,
    S_P_A  = 5'd6,
    S_P_B  = 5'd7,
    S_P_C  = 5'd8,
    S_P_D  = 5'd9,
    S_C_A  = 5'd10,
    S_O_A  = 5'd11,
    S_O_B  = 5'd12,
    S_O_C  = 5'd13,
    S_O_D  = 5'd14,
    S_O_E  = 5'd15,
    S_R_A  = 5'd16,
    S_I_A  = 5'd17,
    S_I_PB = 5'd18,  // interrupt-entry copy of P_B
    S_I_PC = 5'd19,  // interrupt-entry copy of P_C
    S_I_PD = 5'd20,  // interrupt-entry copy of P_D
    S_I_B  = 5'd21,
    S_HALT = 5'd22
  } state_e;

  // ALU function select codes.
  localparam logic [2:0] FN_ADD   = 3'b000;
  localparam logic [2:0] FN_NEG   = 3'b001;
  localparam logic [2:0] FN_INC   = 3'b010;
  localparam logic [2:0] FN_DEC   = 3'b011;
  localparam logic [2:0] FN_OR    = 3'b100;
  localparam logic [2:0] FN_NOT   = 3'b101;
  localparam logic [2:0] FN_TRANS = 3'b110;

  // Bit positions inside ld_en (0..5) and tr_en (0..6).
  localparam int IDX_IR  = 0;
  localparam int IDX_MDR = 1;
  localparam int IDX_MAR = 2;
  localparam int IDX_SP  = 3;
  localparam int IDX_PC  = 4;
  localparam int IDX_T   = 5;
  localparam int IDX_VEC = 6;

  // Opcode class field values (top four opcode bits).
  localparam logic [3:0] CLS_STACK = 4'b1111;
  localparam logic [3:0] CLS_CALL  = 4'b1001;
  localparam logic [3:0] CLS_RET   = 4'b1000;
  localparam logic [3:0] CLS_HALT  = 4'b1110;
  localparam logic [2:0] SUB_PUSH  = 3'b000;

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Control FSM for a small stack machine: fetch, branch, push/pop, call/return,
// halt and vectored interrupt entry. Outputs are pure Moore decodes of the
// state register. OP_W must be at least 7.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W     = 7,
  parameter int STACK_UP = 0,
  parameter int VEC_EN   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] ir,
  input  logic            dcond,
  input  logic            mem_ready,
  input  logic            irq,
  output logic [5:0]      ld_en,
  output logic [6:0]      tr_en,
  output logic            rd,
  output logic            wr,
  output logic            memrd,
  output logic            memwr,
  output logic [2:0]      fnsel,
  output logic            fn_ctl,
  output logic            irq_ack,
  output logic            halted,
  output logic [4:0]      state
);

  state_e     cur;
  state_e     nxt;
  logic       ie;
  logic [3:0] op_class;
  logic [2:0] op_sub;
  logic       take_irq;
  state_e     after_instr;

  // IR only changes in F_B, so it is stable for the rest of the instruction;
  // P_D and O_C can re-read it to tell CALL from PUSH and RET from POP.
  assign op_class    = ir[OP_W-1 -: 4];
  assign op_sub      = ir[2:0];
  assign take_irq    = (VEC_EN != 0) && irq && ie;
  assign after_instr = take_irq ? S_I_A : S_F_A;
  assign state       = cur;

  // State register; reset drops straight to S_RST so all outputs go low at once.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_RST;
    else       cur <= nxt;
  end

  // Interrupt-enable flag: cleared on entry to I_A, set again on entry to R_A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               ie <= 1'b1;
    else if (nxt == S_I_A)   ie <= 1'b0;
    else if (nxt == S_R_A)   ie <= 1'b1;
  end

  // Next-state logic; the three memory states hold while mem_ready is low.
  // NOTE: next-state and output blocks assign every target a default first so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    nxt = cur;
    case (cur)
      S_RST:  nxt = S_F_A;
      S_F_A:  nxt = S_F_B;
      S_F_B:  if (mem_ready) nxt = S_F_C;
      S_F_C: begin
        if (op_class == CLS_STACK)         nxt = (op_sub == SUB_PUSH) ? S_P_A : S_O_A;
        else if (op_class == CLS_CALL)     nxt = S_C_A;
        else if (op_class == CLS_RET)      nxt = S_O_A;
        else if (op_class == CLS_HALT)     nxt = S_HALT;
        else if (!op_class[3] && dcond)    nxt = S_B_A;
        else                               nxt = after_instr;
      end
      S_B_A:  nxt = S_B_B;
      S_B_B:  nxt = after_instr;
      S_P_A:  nxt = S_P_B;
      S_C_A:  nxt = S_P_B;
      S_P_B:  nxt = S_P_C;
      S_P_C:  nxt = S_P_D;
      S_P_D:  if (mem_ready) nxt = (op_class == CLS_CALL) ? S_B_A : after_instr;
      S_O_A:  nxt = S_O_B;
      S_O_B:  if (mem_ready) nxt = S_O_C;
      S_O_C:  nxt = (op_class == CLS_RET) ? S_R_A : S_O_D;
      S_O_D:  nxt = S_O_E;
      S_O_E:  nxt = after_instr;
      S_R_A:  nxt = after_instr;
      S_I_A:  nxt = S_I_PB;
      S_I_PB: nxt = S_I_PC;
      S_I_PC: nxt = S_I_PD;
      S_I_PD: if (mem_ready) nxt = S_I_B;
      S_I_B:  nxt = S_F_A;
      S_HALT: if (take_irq) nxt = S_I_A;
      default: nxt = S_RST;
    endcase
  end

  // Moore output decode: each state names its loads, bus driver and ALU op.
  always_comb begin
    ld_en   = '0;
    tr_en   = '0;
    rd      = 1'b0;
    wr      = 1'b0;
    memrd   = 1'b0;
    memwr   = 1'b0;
    fnsel   = FN_ADD;
    fn_ctl  = 1'b0;
    irq_ack = 1'b0;
    halted  = 1'b0;
    case (cur)
      S_F_A: begin
        ld_en[IDX_MAR] = 1'b1; tr_en[IDX_PC] = 1'b1; fnsel = FN_TRANS; fn_ctl = 1'b1;
      end
      S_F_B: begin
        memrd = 1'b1; tr_en[IDX_MAR] = 1'b1; ld_en[IDX_IR] = 1'b1;
      end
      S_F_C: begin
        ld_en[IDX_PC] = 1'b1; tr_en[IDX_PC] = 1'b1; fnsel = FN_INC; fn_ctl = 1'b1;
      end
      S_B_A: begin
        ld_en[IDX_T] = 1'b1; tr_en[IDX_IR] = 1'b1;
      end
      S_B_B: begin
        ld_en[IDX_PC] = 1'b1; tr_en[IDX_T] = 1'b1; fnsel = FN_ADD; fn_ctl = 1'b1;
      end
      S_P_A: begin
        ld_en[IDX_MDR] = 1'b1; rd = 1'b1; fnsel = FN_TRANS; fn_ctl = 1'b1;
      end
      S_P_B, S_I_PB: begin
        ld_en[IDX_SP] = 1'b1; tr_en[IDX_SP] = 1'b1; fn_ctl = 1'b1;
        fnsel = (STACK_UP != 0) ? FN_INC : FN_DEC;
      end
      S_P_C, S_I_PC: begin
        ld_en[IDX_MAR] = 1'b1; tr_en[IDX_SP] = 1'b1; fnsel = FN_TRANS; fn_ctl = 1'b1;
      end
      S_P_D, S_I_PD: begin
        memwr = 1'b1; tr_en[IDX_MDR] = 1'b1;
      end
      S_C_A, S_I_A: begin
        ld_en[IDX_MDR] = 1'b1; tr_en[IDX_PC] = 1'b1; fnsel = FN_TRANS; fn_ctl = 1'b1;
      end
      S_O_A: begin
        ld_en[IDX_MAR] = 1'b1; tr_en[IDX_SP] = 1'b1; fnsel = FN_TRANS; fn_ctl = 1'b1;
      end
      S_O_B: begin
        memrd = 1'b1; ld_en[IDX_MDR] = 1'b1;
      end
      S_O_C: begin
        ld_en[IDX_SP] = 1'b1; tr_en[IDX_SP] = 1'b1; fn_ctl = 1'b1;
        fnsel = (STACK_UP != 0) ? FN_DEC : FN_INC;
      end
      S_O_D: begin
        ld_en[IDX_T] = 1'b1; tr_en[IDX_MDR] = 1'b1;
      end
      S_O_E: begin
        tr_en[IDX_T] = 1'b1; wr = 1'b1;
      end
      S_R_A: begin
        ld_en[IDX_PC] = 1'b1; tr_en[IDX_MDR] = 1'b1; fnsel = FN_TRANS; fn_ctl = 1'b1;
      end
      S_I_B: begin
        ld_en[IDX_PC] = 1'b1; tr_en[IDX_VEC] = 1'b1; fnsel = FN_TRANS; fn_ctl = 1'b1;
        irq_ack = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
